// File: rtl/serial_frame_rx_pkg.sv
// Shared types and constants for the serial frame receiver.
//   rx_state_t  : receiver FSM states (PARITY only reachable with SERIAL_FRAME_RX_PARITY_EN)
//   SYNC_STAGES : depth of the serial_in synchronizer
package serial_frame_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        LOAD
    } rx_state_t;

    localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/flex_stp_sr.sv
// Parameterized serial-to-parallel shift register.
// SHIFT_MSB=1 shifts toward the MSB (first bit in ends at parallel_out[NUM_BITS-1]);
// SHIFT_MSB=0 shifts toward the LSB (first bit in ends at parallel_out[0]).
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset, loads all ones
//   shift_enable : shift serial_in in this cycle
//   serial_in    : bit to shift in
//   parallel_out : current register contents
module flex_stp_sr #(
    parameter int unsigned NUM_BITS  = 8,
    parameter bit          SHIFT_MSB = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                shift_enable,
    input  logic                serial_in,
    output logic [NUM_BITS-1:0] parallel_out
);

    logic [NUM_BITS-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '1;
        end else if (shift_enable) begin
            if (SHIFT_MSB) begin
                data_q <= {data_q[NUM_BITS-2:0], serial_in};
            end else begin
                data_q <= {serial_in, data_q[NUM_BITS-1:1]};
            end
        end
    end

    assign parallel_out = data_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial-to-parallel frame receiver for an idle-high framed serial line.
// Detects the start bit on the synchronized line, samples each bit at mid-bit,
// checks the stop bit and presents the word with a ready/read handshake.
// Optional feature macro: SERIAL_FRAME_RX_PARITY_EN adds one even-parity bit
// between the data bits and the stop bit.
// Ports:
//   clk           : clock, rising edge
//   rst           : synchronous active-high reset
//   serial_in     : asynchronous serial line, idle high
//   data_read     : consumer acknowledge pulse for rx_data
//   rx_data       : last valid received word
//   data_ready    : rx_data holds an unread word
//   framing_error : last frame had stop bit = 0
//   overrun_error : a valid word overwrote an unread word
//   parity_error  : last frame failed the parity check (0 without the macro)
//   rx_busy       : FSM not in IDLE
module serial_frame_rx
    import serial_frame_rx_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 10,
    parameter int unsigned MSB_FIRST    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    input  logic                 data_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 framing_error,
    output logic                 overrun_error,
    output logic                 parity_error,
    output logic                 rx_busy
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam int unsigned CW = $clog2(DATA_BITS + 1);

    // The timer starts at 0 on the cycle after each sample point, so a sample
    // lands when it reads N-1.
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DATA_BITS - 1);

    // Synchronizer and edge detect
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   line_prev_q;
    logic                   line;
    logic                   fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= '1;
            line_prev_q <= 1'b1;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], serial_in};
            line_prev_q <= line;
        end
    end

    assign line = sync_q[SYNC_STAGES-1];
    assign fall = line_prev_q & ~line;

    // FSM, bit timer, bit counter
    rx_state_t     state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic          stop_q, stop_d;
    logic          shift_en;
    logic [DATA_BITS-1:0] shift_data;

`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic parity_bit_q, parity_bit_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            stop_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            stop_q    <= stop_d;
        end
    end

`ifdef SERIAL_FRAME_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_bit_q <= 1'b0;
        end else begin
            parity_bit_q <= parity_bit_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + TW'(1);
        bit_cnt_d = bit_cnt_q;
        stop_d    = stop_q;
        shift_en  = 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
        parity_bit_d = parity_bit_q;
`endif
        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (fall) begin
                    state_d = START;
                end
            end
            START: begin
                if (timer_q == HALF_LAST) begin
                    timer_d   = '0;
                    bit_cnt_d = '0;
                    // Line already back high at mid start bit: treat as a glitch.
                    state_d   = line ? IDLE : DATA;
                end
            end
            DATA: begin
                if (timer_q == TIMER_LAST) begin
                    timer_d  = '0;
                    shift_en = 1'b1;
                    if (bit_cnt_q == CNT_LAST) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
            end
            PARITY: begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                if (timer_q == TIMER_LAST) begin
                    timer_d      = '0;
                    parity_bit_d = line;
                    state_d      = STOP;
                end
`else
                timer_d = '0;
                state_d = IDLE;
`endif
            end
            STOP: begin
                if (timer_q == TIMER_LAST) begin
                    timer_d = '0;
                    stop_d  = line;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                timer_d = '0;
                state_d = IDLE;
            end
            default: begin
                timer_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    flex_stp_sr #(
        .NUM_BITS  (DATA_BITS),
        .SHIFT_MSB (MSB_FIRST != 0)
    ) u_shift (
        .clk          (clk),
        .rst          (rst),
        .shift_enable (shift_en),
        .serial_in    (line),
        .parallel_out (shift_data)
    );

    // Output registers
    logic                 load_cycle;
    logic                 parity_ok;
    logic                 valid_load;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 data_ready_q, data_ready_d;
    logic                 framing_q, framing_d;
    logic                 overrun_q, overrun_d;

`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic parity_err_q, parity_err_d;
    // Even parity: data bits plus parity bit carry an even number of ones.
    assign parity_ok = ~(^{shift_data, parity_bit_q});
`else
    assign parity_ok = 1'b1;
`endif

    assign load_cycle = (state_q == LOAD);
    assign valid_load = load_cycle & stop_q & parity_ok;

    always_comb begin
        rx_data_d    = rx_data_q;
        data_ready_d = data_ready_q;
        framing_d    = framing_q;
        overrun_d    = overrun_q;
`ifdef SERIAL_FRAME_RX_PARITY_EN
        parity_err_d = parity_err_q;
`endif
        if (valid_load) begin
            rx_data_d    = shift_data;
            data_ready_d = 1'b1;
            framing_d    = 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            parity_err_d = 1'b0;
`endif
            // A read in the same cycle consumes the old word, so no overrun.
            if (data_ready_q && !data_read) begin
                overrun_d = 1'b1;
            end else if (data_read) begin
                overrun_d = 1'b0;
            end
        end else begin
            if (load_cycle && !stop_q) begin
                framing_d = 1'b1;
            end
`ifdef SERIAL_FRAME_RX_PARITY_EN
            if (load_cycle && stop_q && !parity_ok) begin
                parity_err_d = 1'b1;
            end
`endif
            if (data_read) begin
                data_ready_d = 1'b0;
                overrun_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_q    <= '1;
            data_ready_q <= 1'b0;
            framing_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_data_q    <= rx_data_d;
            data_ready_q <= data_ready_d;
            framing_q    <= framing_d;
            overrun_q    <= overrun_d;
        end
    end

`ifdef SERIAL_FRAME_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_error = parity_err_q;
`else
    assign parity_error = 1'b0;
`endif

    assign rx_data       = rx_data_q;
    assign data_ready    = data_ready_q;
    assign framing_error = framing_q;
    assign overrun_error = overrun_q;
    assign rx_busy       = (state_q != IDLE);

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Serial-to-parallel frame receiver: the receive end of the team's framed serial link driven by the parallel-to-serial shift-register transmitter. It oversamples an idle-high serial line and detects the start bit. Each data bit is sampled at mid-bit and assembled into a parallel word. The block checks the stop bit and presents the word with a ready/read handshake plus framing and overrun status.

## Interface
- DATA_BITS, 8, data bits per frame (≥2)
- CLKS_PER_BIT, 10, clock cycles per serial bit (≥4)
- MSB_FIRST, 1, 1: first data bit received lands in rx_data[DATA_BITS-1]; 0: lands in rx_data[0]
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  reset; synchronous, active-high
- serial_in  input  1  asynchronous serial line, idle high
- data_read  input  1  consumer pulse; acknowledges rx_data
- rx_data  output  DATA_BITS  last valid received word
- data_ready  output  1  rx_data holds an unread word
- framing_error  output  1  last frame had stop bit = 0
- overrun_error  output  1  valid word overwrote an unread word
- parity_error  output  1  see Configuration
- rx_busy  output  1  FSM not in IDLE

## Operation
- serial_in passes through a 2-flop synchronizer (flops reset to 1). Edge detect is done on the synchronized line: previous 1, current 0.
- FSM states: IDLE, START, DATA, STOP, LOAD.
- IDLE: on falling edge → START, bit timer cleared.
- START: at timer = CLKS_PER_BIT/2 (floor), sample line. 0 → DATA, timer cleared. 1 → false start, back to IDLE.
- DATA: every CLKS_PER_BIT cycles, sample and shift one bit in per MSB_FIRST. After DATA_BITS samples → STOP.
- STOP: after CLKS_PER_BIT cycles, sample and latch the stop bit → LOAD.
- LOAD (one cycle), then → IDLE:
  - stop=1: rx_data ← shift register, data_ready ← 1, framing_error ← 0. If data_ready was already 1 and data_read is low this cycle, overrun_error ← 1 (the new word still overwrites).
  - stop=0: framing_error ← 1; rx_data, data_ready and overrun_error unchanged.
- data_read high (not in a valid LOAD cycle): data_ready ← 0 and overrun_error ← 0 next cycle. framing_error is cleared only by the next valid frame or by reset.
- data_read in the same cycle as a valid LOAD: LOAD wins, so data_ready stays 1. overrun_error is not set.
- The line is ignored outside IDLE edge detect and the sample points. A new frame needs no extra idle time beyond the stop bit.

## Timing
- Reset values: rx_data all ones, data_ready 0, framing_error 0, overrun_error 0, parity_error 0, rx_busy 0, FSM IDLE, timer 0.
- rst mid-frame: the next cycle equals the reset state and the partial frame is discarded.
- Let E = cycle the synchronized falling edge is seen (2 cycles after the pin edge).
  - Start sample at E+H, where H = CLKS_PER_BIT/2.
  - Data bit k (0-based) sampled at E+H+(k+1)·CLKS_PER_BIT.
  - Stop bit sampled at E+H+(DATA_BITS+1)·CLKS_PER_BIT. LOAD is the following cycle.
  - Outputs update on the cycle after LOAD.
- rx_busy is high from E+1 through LOAD inclusive.
- Bit timer width is $clog2(CLKS_PER_BIT). Bit counter width is $clog2(DATA_BITS+1).

## Configuration
- SERIAL_FRAME_RX_PARITY_EN defined:
  - One even-parity bit follows the data bits, sampled CLKS_PER_BIT after the last data bit. STOP sampling shifts one bit period later.
  - Parity mismatch with stop=1: parity_error ← 1; rx_data and data_ready unchanged.
  - Valid frame: parity_error ← 0.
- Not defined: no parity bit; parity_error is tied 0.

## Structure
- Package serial_frame_rx_pkg holds:
  - typedef enum rx_state_t {IDLE, START, DATA, PARITY, STOP, LOAD}. PARITY is unused without the macro.
  - Constant SYNC_STAGES = 2.
- Sub-module flex_stp_sr: parameterized serial-to-parallel shift register (NUM_BITS, SHIFT_MSB). Ports: clk, rst, shift_enable, serial_in, parallel_out; resets to all ones.
- Bit timer and bit counter stay inline.

## Test plan
Defaults unless noted: DATA_BITS=8, CLKS_PER_BIT=10, MSB_FIRST=1.
- Valid frame 0xA5, stop=1 → rx_data=0xA5 and data_ready=1 at E+H+91+1, framing_error=0; data_read → data_ready=0 next cycle.
- Line low 3 cycles then high (glitch) → FSM back to IDLE at E+H; no data_ready; rx_busy low.
- Frame 0x3C with stop=0 after 0xA5 was read → framing_error=1, rx_data stays 0xA5, data_ready stays 0.
- Frames 0x11 then 0x22, no data_read → rx_data=0x22, overrun_error=1; then data_read → data_ready=0, overrun_error=0.
- rst pulsed during data bit 4 → all reset values next cycle; following frame 0x5A received correctly. Repeat 0x5A with MSB_FIRST=0 → rx_data=0x5A.
- With SERIAL_FRAME_RX_PARITY_EN: frame 0x07 with parity bit 0 → parity_error=1, data_ready stays 0. Same frame with parity bit 1 → rx_data=0x07, parity_error=0.
